hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised hazard detection and forwarding control for the 5-stage ARM pipeline, succeeding the single-cycle load-use detector. It sits beside the ID/EXE boundary and does three things:
- Stalls IF/ID on read-after-write hazards, with separate rules for forwarding enabled and disabled.
- Stretches load-use stalls over a configurable load latency.
- Drives the EXE-stage operand forwarding muxes and keeps a saturating stall-cycle statistic.

## Interface
Parameters:
- REG_W, 4: register address width.
- LOAD_LAT, 1: stall cycles per load-use hazard; legal range 1..15.
- CNT_W, 16: width of the stall statistic counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- id_valid  in  1  ID holds a real instruction.
- id_two_src  in  1  ID instruction reads src2.
- id_src1, id_src2  in  REG_W  ID source registers.
- exe_dest  in  REG_W  EXE-stage destination.
- exe_wb_en  in  1  EXE-stage write-back enable.
- exe_mem_r_en  in  1  EXE-stage instruction is a load.
- mem_dest  in  REG_W  MEM-stage destination.
- mem_wb_en  in  1  MEM-stage write-back enable.
- wb_dest  in  REG_W  WB-stage destination.
- wb_wb_en  in  1  WB-stage write-back enable.
- exe_src1, exe_src2  in  REG_W  source registers of the EXE-stage instruction.
- flush  in  1  branch taken; ID/EXE contents are squashed.
- stat_clr  in  1  clear the statistic counter.
- hazard  out  1  stall IF/ID, insert bubble into EXE.
- sel_src1, sel_src2  out  2  forwarding select: 0 = register file, 1 = MEM-stage result, 2 = WB-stage result; 3 is never driven.
- stall_count  out  CNT_W  saturating count of cycles with hazard=1.

## Operation
Match terms:
- m1x = (id_src1 == exe_dest)
- m2x = id_two_src & (id_src2 == exe_dest)
- m1m, m2m: the same two terms against mem_dest.

Raw hazard, raw_hz:
- fwd_en=1: id_valid & exe_mem_r_en & (m1x | m2x). This is the load-use case.
- fwd_en=0: id_valid & ((exe_wb_en & (m1x|m2x)) | (mem_wb_en & (m1m|m2m))).

Load-stall extension, in stall-only mode this counter is never loaded:
- Register ext_cnt, 4 bits. States: IDLE (ext_cnt=0) and EXTEND (ext_cnt≠0).
- IDLE→EXTEND when fwd_en & raw_hz & LOAD_LAT>1; ext_cnt loads LOAD_LAT-1.
- In EXTEND, ext_cnt decrements by 1 per cycle and returns to IDLE at 0.
- New raw hazards during EXTEND do not reload the counter.

Outputs:
- hazard = ~rst & ~flush & (raw_hz | ext_cnt≠0).
- flush=1: hazard forced 0 and ext_cnt cleared next edge. flush beats a simultaneous raw_hz.
- fwd_en toggling mid-EXTEND does not abort the extension.

Forwarding, when fwd_en=1 and rst=0, per operand (shown for src1):
- sel_src1 = 1 if mem_wb_en & exe_src1==mem_dest.
- Else 2 if wb_wb_en & exe_src1==wb_dest.
- Else 0.
- MEM has priority over WB when both match.
- fwd_en=0 or rst=1: both sels = 0.
- sel_src2 follows the same rules on exe_src2, regardless of two_src.

Statistic counter:
- stall_count increments when hazard=1.
- Saturates at 2^CNT_W-1.
- Cleared by rst or stat_clr; stat_clr beats increment.

## Timing
- hazard, sel_src1, sel_src2 are combinational from current inputs plus ext_cnt; zero-cycle latency.
- Load-use in forwarding mode detected in cycle T: hazard=1 in cycles T..T+LOAD_LAT-1, then 0 in T+LOAD_LAT unless a new raw_hz is present.
- LOAD_LAT=1 is exactly one stall cycle, with no state used.
- stall_count reflects the cycle-T hazard at edge T+1.
- Reset values: ext_cnt=0, stall_count=0. While rst is asserted, hazard=0 and sel=0.
- rst asserted mid-EXTEND: ext_cnt=0 after the edge and hazard=0 during the rst cycle.
- Register address compares are full REG_W width with no special-casing of R15.

## Test plan
- Load-use, LOAD_LAT=1, fwd_en=1: exe_mem_r_en=1, exe_dest=3, id_src1=3, id_valid=1 → hazard=1 for 1 cycle; stall_count 0→1.
- Load-use, LOAD_LAT=3, fwd_en=1: same stimulus for 1 cycle, then exe_mem_r_en=0 → hazard=1 for 3 consecutive cycles, then 0; stall_count=3.
- Stall-only mode: fwd_en=0, mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 → hazard=1. Same with id_two_src=0 → hazard=0.
- Forward priority: fwd_en=1, mem_dest=wb_dest=7, both wb_en=1, exe_src1=7, exe_src2=2 → sel_src1=1, sel_src2=0. Deassert mem_wb_en → sel_src1=2.
- Flush and reset: LOAD_LAT=4, EXTEND entered; flush=1 with raw_hz=1 in the next cycle → hazard=0 that cycle, ext_cnt=0 after. Repeat with rst instead → hazard=0, stall_count=0.
- Saturation: CNT_W=4, hold a continuous hazard for 20 cycles → stall_count=15. stat_clr together with hazard → stall_count=0.

Source files
------------

// File: rtl/hazard_forward_if.sv
// hazard_forward_if: pipeline-side signals for the hazard/forwarding unit
interface hazard_forward_if #(parameter int REG_W = 4, parameter int CNT_W = 16);
  logic fwd_en, id_valid, id_two_src;
  logic [REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest, wb_dest, exe_src1, exe_src2;
  logic exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en, flush, stat_clr;
  logic hazard;
  logic [1:0] sel_src1, sel_src2;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output fwd_en, id_valid, id_two_src, id_src1, id_src2, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, wb_dest, wb_wb_en, exe_src1, exe_src2, flush, stat_clr,
    input  hazard, sel_src1, sel_src2, stall_count
  );
  modport slave (
    input  fwd_en, id_valid, id_two_src, id_src1, id_src2, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, wb_dest, wb_wb_en, exe_src1, exe_src2, flush, stat_clr,
    output hazard, sel_src1, sel_src2, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: RAW stall detection, load-latency stretch, EXE forwarding selects
module hazard_forward_unit #(
  parameter int REG_W    = 4,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  hazard_forward_if.slave bus
);
  logic m1x, m2x, m1m, m2m, raw_hz, ext_on;
  logic [3:0] ext_cnt;
  function automatic logic eq(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return a == b;
  endfunction
  function automatic logic [1:0] sel(input logic [REG_W-1:0] src);
    return (rst || !bus.fwd_en) ? 2'd0 :
           (bus.mem_wb_en && eq(src, bus.mem_dest)) ? 2'd1 :
           (bus.wb_wb_en && eq(src, bus.wb_dest)) ? 2'd2 : 2'd0;
  endfunction
  assign m1x = eq(bus.id_src1, bus.exe_dest);
  assign m2x = bus.id_two_src & eq(bus.id_src2, bus.exe_dest);
  assign m1m = eq(bus.id_src1, bus.mem_dest);
  assign m2m = bus.id_two_src & eq(bus.id_src2, bus.mem_dest);
  // with forwarding only a load in EXE can't be bypassed in time
  assign raw_hz = bus.id_valid & (bus.fwd_en ? bus.exe_mem_r_en & (m1x | m2x)
                                             : (bus.exe_wb_en & (m1x | m2x)) | (bus.mem_wb_en & (m1m | m2m)));
  assign ext_on = ext_cnt != 4'd0;
  assign bus.hazard = ~rst & ~bus.flush & (raw_hz | ext_on);
  assign bus.sel_src1 = sel(bus.exe_src1);
  assign bus.sel_src2 = sel(bus.exe_src2);
  always_ff @(posedge clk) begin
    if (rst || bus.flush) ext_cnt <= 4'd0;
    else if (ext_on) ext_cnt <= ext_cnt - 4'd1;
    else if (bus.fwd_en && raw_hz && LOAD_LAT > 1) ext_cnt <= 4'(LOAD_LAT - 1);
    if (rst || bus.stat_clr) bus.stall_count <= '0;
    else if (bus.hazard && bus.stall_count != {CNT_W{1'b1}}) bus.stall_count <= bus.stall_count + 1'b1;
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vectors over three instances (LOAD_LAT 1, 3, 4; CNT_W 4)
module tb_hazard_forward_unit;
  typedef struct packed {
    logic fwd_en, id_valid, id_two_src;
    logic [3:0] id_src1, id_src2, exe_dest;
    logic exe_wb_en, exe_mem_r_en;
    logic [3:0] mem_dest;
    logic mem_wb_en;
    logic [3:0] wb_dest;
    logic wb_wb_en;
    logic [3:0] exe_src1, exe_src2;
    logic flush, stat_clr;
  } in_t;
  typedef struct {
    in_t i;
    logic hz;
    logic [1:0] s1;
    logic [1:0] s2;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t cur, idle, lu, v, sv, r;
  logic hz [3];
  logic [1:0] s1 [3];
  logic [1:0] s2 [3];
  logic [3:0] sc [3];
  int n_chk = 0;
  int n_err = 0;
  vec_t tbl [18];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    hazard_forward_if #(.REG_W(4), .CNT_W(4)) bus ();
    assign bus.fwd_en = cur.fwd_en;
    assign bus.id_valid = cur.id_valid;
    assign bus.id_two_src = cur.id_two_src;
    assign bus.id_src1 = cur.id_src1;
    assign bus.id_src2 = cur.id_src2;
    assign bus.exe_dest = cur.exe_dest;
    assign bus.exe_wb_en = cur.exe_wb_en;
    assign bus.exe_mem_r_en = cur.exe_mem_r_en;
    assign bus.mem_dest = cur.mem_dest;
    assign bus.mem_wb_en = cur.mem_wb_en;
    assign bus.wb_dest = cur.wb_dest;
    assign bus.wb_wb_en = cur.wb_wb_en;
    assign bus.exe_src1 = cur.exe_src1;
    assign bus.exe_src2 = cur.exe_src2;
    assign bus.flush = cur.flush;
    assign bus.stat_clr = cur.stat_clr;
    assign hz[g] = bus.hazard;
    assign s1[g] = bus.sel_src1;
    assign s2[g] = bus.sel_src2;
    assign sc[g] = bus.stall_count;
    hazard_forward_unit #(.REG_W(4), .LOAD_LAT(g == 0 ? 1 : g == 1 ? 3 : 4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
  end
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step(input in_t nv);
    @(negedge clk);
    cur = nv;
    #1;
  endtask
  initial begin
    idle = '{default: '0, fwd_en: 1'b1};
    lu = '{default: '0, fwd_en: 1'b1, id_valid: 1'b1, exe_mem_r_en: 1'b1, exe_dest: 4'd3, id_src1: 4'd3};
    tbl[0]  = '{'{default: '0, fwd_en: 1'b1, id_valid: 1'b1, exe_mem_r_en: 1'b1, exe_dest: 4'd3, id_src1: 4'd3}, 1'b1, 2'd0, 2'd0};
    tbl[1]  = '{'{default: '0, fwd_en: 1'b1, exe_mem_r_en: 1'b1, exe_dest: 4'd3, id_src1: 4'd3}, 1'b0, 2'd0, 2'd0};
    tbl[2]  = '{'{default: '0, fwd_en: 1'b1, id_valid: 1'b1, exe_wb_en: 1'b1, exe_dest: 4'd3, id_src1: 4'd3}, 1'b0, 2'd0, 2'd0};
    tbl[3]  = '{'{default: '0, fwd_en: 1'b1, id_valid: 1'b1, id_two_src: 1'b1, exe_mem_r_en: 1'b1, exe_dest: 4'd3, id_src1: 4'd1, id_src2: 4'd3}, 1'b1, 2'd0, 2'd0};
    tbl[4]  = '{'{default: '0, fwd_en: 1'b1, id_valid: 1'b1, exe_mem_r_en: 1'b1, exe_dest: 4'd3, id_src1: 4'd1, id_src2: 4'd3}, 1'b0, 2'd0, 2'd0};
    tbl[5]  = '{'{default: '0, id_valid: 1'b1, id_two_src: 1'b1, mem_wb_en: 1'b1, mem_dest: 4'd5, id_src1: 4'd1, id_src2: 4'd5, exe_dest: 4'd9}, 1'b1, 2'd0, 2'd0};
    tbl[6]  = '{'{default: '0, id_valid: 1'b1, mem_wb_en: 1'b1, mem_dest: 4'd5, id_src1: 4'd1, id_src2: 4'd5, exe_dest: 4'd9}, 1'b0, 2'd0, 2'd0};
    tbl[7]  = '{'{default: '0, id_valid: 1'b1, exe_wb_en: 1'b1, exe_dest: 4'd6, id_src1: 4'd6}, 1'b1, 2'd0, 2'd0};
    tbl[8]  = '{'{default: '0, id_valid: 1'b1, exe_mem_r_en: 1'b1, exe_dest: 4'd6, id_src1: 4'd6}, 1'b0, 2'd0, 2'd0};
    tbl[9]  = '{'{default: '0, fwd_en: 1'b1, id_valid: 1'b1, exe_mem_r_en: 1'b1, exe_dest: 4'd3, id_src1: 4'd3, flush: 1'b1}, 1'b0, 2'd0, 2'd0};
    tbl[10] = '{'{default: '0, fwd_en: 1'b1, mem_dest: 4'd7, wb_dest: 4'd7, mem_wb_en: 1'b1, wb_wb_en: 1'b1, exe_src1: 4'd7, exe_src2: 4'd2}, 1'b0, 2'd1, 2'd0};
    tbl[11] = '{'{default: '0, fwd_en: 1'b1, mem_dest: 4'd7, wb_dest: 4'd7, wb_wb_en: 1'b1, exe_src1: 4'd7, exe_src2: 4'd2}, 1'b0, 2'd2, 2'd0};
    tbl[12] = '{'{default: '0, mem_dest: 4'd7, wb_dest: 4'd7, mem_wb_en: 1'b1, wb_wb_en: 1'b1, exe_src1: 4'd7, exe_src2: 4'd2}, 1'b0, 2'd0, 2'd0};
    tbl[13] = '{'{default: '0, fwd_en: 1'b1, mem_dest: 4'd2, wb_dest: 4'd2, wb_wb_en: 1'b1, exe_src1: 4'd2, exe_src2: 4'd2}, 1'b0, 2'd2, 2'd2};
    tbl[14] = '{'{default: '0, fwd_en: 1'b1, mem_dest: 4'd15, mem_wb_en: 1'b1, wb_dest: 4'd4, wb_wb_en: 1'b1, exe_src1: 4'd4, exe_src2: 4'd15}, 1'b0, 2'd2, 2'd1};
    tbl[15] = '{'{default: '0, fwd_en: 1'b1, mem_dest: 4'd5, wb_dest: 4'd5, exe_src1: 4'd5, exe_src2: 4'd5}, 1'b0, 2'd0, 2'd0};
    tbl[16] = '{'{default: '0, fwd_en: 1'b1, id_valid: 1'b1, id_two_src: 1'b1, mem_wb_en: 1'b1, mem_dest: 4'd5, id_src1: 4'd1, id_src2: 4'd5, exe_dest: 4'd9}, 1'b0, 2'd0, 2'd0};
    tbl[17] = '{'{default: '0, id_valid: 1'b1, id_two_src: 1'b1, exe_wb_en: 1'b1, exe_dest: 4'd8, id_src1: 4'd1, id_src2: 4'd8}, 1'b1, 2'd0, 2'd0};
    cur = idle;
    step(lu);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset hazard u%0d", g), hz[g], 1'b0);
      chk($sformatf("reset stall_count u%0d", g), sc[g], 4'd0);
    end
    step(idle);
    rst = 1'b0;
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].i);
      chk($sformatf("vec%0d hazard", k), hz[0], tbl[k].hz);
      chk($sformatf("vec%0d sel_src1", k), s1[0], tbl[k].s1);
      chk($sformatf("vec%0d sel_src2", k), s2[0], tbl[k].s2);
    end
    rst = 1'b1;
    step(idle);
    step(idle);
    rst = 1'b0;
    step(lu);
    chk("lat hz T u1", hz[0], 1'b1);
    chk("lat hz T u3", hz[1], 1'b1);
    chk("lat hz T u4", hz[2], 1'b1);
    step(idle);
    chk("lat hz T+1 u1", hz[0], 1'b0);
    chk("lat hz T+1 u3", hz[1], 1'b1);
    chk("lat hz T+1 u4", hz[2], 1'b1);
    chk("lat count u1", sc[0], 4'd1);
    chk("lat count T+1 u3", sc[1], 4'd1);
    step(idle);
    chk("lat hz T+2 u3", hz[1], 1'b1);
    chk("lat hz T+2 u4", hz[2], 1'b1);
    step(idle);
    chk("lat hz T+3 u3", hz[1], 1'b0);
    chk("lat hz T+3 u4", hz[2], 1'b1);
    chk("lat count u3", sc[1], 4'd3);
    step(idle);
    chk("lat hz T+4 u4", hz[2], 1'b0);
    chk("lat count u4", sc[2], 4'd4);
    chk("lat count held u1", sc[0], 4'd1);
    step(lu);
    step(lu);
    chk("noreload hz T+1 u3", hz[1], 1'b1);
    step(idle);
    chk("noreload hz T+2 u3", hz[1], 1'b1);
    step(idle);
    chk("noreload hz T+3 u3", hz[1], 1'b0);
    chk("noreload hz T+3 u4", hz[2], 1'b1);
    step(idle);
    chk("noreload hz T+4 u4", hz[2], 1'b0);
    step(lu);
    v = idle;
    v.fwd_en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(v);
      chk($sformatf("fwd toggle hz T+%0d u4", k), hz[2], 1'b1);
    end
    step(v);
    chk("fwd toggle hz T+4 u4", hz[2], 1'b0);
    sv = '{default: '0, id_valid: 1'b1, exe_wb_en: 1'b1, exe_dest: 4'd6, id_src1: 4'd6};
    step(sv);
    chk("stall-only hz u4", hz[2], 1'b1);
    chk("stall-only hz u3", hz[1], 1'b1);
    step(v);
    chk("stall-only no extend u4", hz[2], 1'b0);
    chk("stall-only no extend u3", hz[1], 1'b0);
    step(lu);
    v = lu;
    v.flush = 1'b1;
    step(v);
    for (int g = 0; g < 3; g++) chk($sformatf("flush hz u%0d", g), hz[g], 1'b0);
    step(idle);
    chk("after flush hz u4", hz[2], 1'b0);
    chk("after flush hz u3", hz[1], 1'b0);
    step(lu);
    r = lu;
    r.mem_wb_en = 1'b1;
    r.mem_dest = 4'd3;
    r.exe_src1 = 4'd3;
    r.exe_src2 = 4'd3;
    @(negedge clk);
    cur = r;
    rst = 1'b1;
    #1;
    chk("rst hz u4", hz[2], 1'b0);
    chk("rst sel_src1", s1[0], 2'd0);
    chk("rst sel_src2", s2[0], 2'd0);
    @(negedge clk);
    cur = idle;
    rst = 1'b0;
    #1;
    chk("after rst hz u4", hz[2], 1'b0);
    chk("after rst count u4", sc[2], 4'd0);
    chk("after rst count u1", sc[0], 4'd0);
    for (int k = 0; k <= 20; k++) begin
      step(lu);
      if (k == 5) chk("sat count k5", sc[0], 4'd5);
    end
    chk("sat count u1", sc[0], 4'd15);
    chk("sat count u3", sc[1], 4'd15);
    v = lu;
    v.stat_clr = 1'b1;
    step(v);
    chk("sat held", sc[0], 4'd15);
    step(lu);
    chk("stat_clr beats inc", sc[0], 4'd0);
    step(lu);
    chk("count after clr", sc[0], 4'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
